apb_req_arbiter: RTL and testbench

- Shares one apb_adapter transaction port (valid/ready/write/addr/din, dout_vld/dout) between NREQ independent requesters, e.g. I2C controller, init sequencer and debug access.
- Round-robin arbitration with one outstanding transaction at a time, per-requester response routing, optional bus lock for atomic multi-access sequences, and a read-response timeout.
- Sits between the I2C control FSMs and apb_adapter.

---
 rtl/apb_req_arbiter_if.sv | 42 ++++
 rtl/apb_req_arbiter.sv | 169 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// Requester-side and adapter-side signals of the APB request arbiter.
// The arbiter uses the master modport; the environment uses the slave modport.
interface apb_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_write;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_din;
    logic [NREQ-1:0]    rsp_vld;
    logic               rsp_err;
    logic [DW-1:0]      rsp_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_write;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_din;
    logic               m_dout_vld;
    logic [DW-1:0]      m_dout;
    logic [IDW-1:0]     grant_id;
    logic               busy;

    modport master (
        input  req_valid, req_write, req_lock, req_addr, req_din,
        input  m_ready, m_dout_vld, m_dout,
        output req_ready, rsp_vld, rsp_err, rsp_data,
        output m_valid, m_write, m_addr, m_din, grant_id, busy
    );

    modport slave (
        output req_valid, req_write, req_lock, req_addr, req_din,
        output m_ready, m_dout_vld, m_dout,
        input  req_ready, rsp_vld, rsp_err, rsp_data,
        input  m_valid, m_write, m_addr, m_din, grant_id, busy
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_adapter transaction port between NREQ requesters,
// with one outstanding transaction, optional bus lock and a read-response timeout.
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic            clk,
    input logic            rst_n,
    apb_req_arbiter_if.master bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic            wr_q, wr_d;
    logic            lock_q, lock_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] rsp_vld_q, rsp_vld_d;
    logic            rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  sel;
    logic [NREQ-1:0] ready_c;
    logic            accept;
    logic            done;
    logic            done_err;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found && bus.req_valid[(int'(last_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = IDW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        wr_d       = wr_q;
        lock_d     = lock_q;
        addr_d     = addr_q;
        din_d      = din_q;
        cnt_d      = cnt_q;
        rsp_vld_d  = '0;
        rsp_err_d  = 1'b0;
        rsp_data_d = rsp_data_q;
        ready_c    = '0;
        accept     = 1'b0;
        done       = 1'b0;
        done_err   = 1'b0;
        sel        = (state_q == LOCKED) ? grant_q : win_idx;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    ready_c[win_idx] = 1'b1;
                    accept           = 1'b1;
                    last_d           = win_idx;
                    grant_d          = win_idx;
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_ready) begin
                    if (wr_q) begin
                        done = 1'b1;
                    end else if (bus.m_dout_vld) begin
                        done       = 1'b1;
                        rsp_data_d = bus.m_dout;
                    end else begin
                        state_d = WAIT_RD;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.m_dout_vld) begin
                    done       = 1'b1;
                    rsp_data_d = bus.m_dout;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    done       = 1'b1;
                    done_err   = 1'b1;
                    rsp_data_d = '0;
                end
            end
            LOCKED: begin
                // Only the lock holder is eligible; everyone else stalls.
                if (bus.req_valid[grant_q]) begin
                    ready_c[grant_q] = 1'b1;
                    accept           = 1'b1;
                    state_d          = ISSUE;
                end else if (!bus.req_lock[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            wr_d   = bus.req_write[sel];
            lock_d = bus.req_lock[sel];
            addr_d = bus.req_addr[int'(sel)*AW +: AW];
            din_d  = bus.req_din[int'(sel)*DW +: DW];
        end

        if (done) begin
            rsp_vld_d[grant_q] = 1'b1;
            rsp_err_d          = done_err;
            state_d            = lock_q ? LOCKED : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= IDW'(NREQ - 1);
            grant_q    <= '0;
            wr_q       <= 1'b0;
            lock_q     <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            cnt_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            wr_q       <= wr_d;
            lock_q     <= lock_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            cnt_q      <= cnt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Grant is combinational, so it must be masked while reset is asserted.
    assign bus.req_ready = rst_n ? ready_c : '0;
    assign bus.rsp_vld   = rsp_vld_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.m_valid   = (state_q == ISSUE);
    assign bus.m_write   = wr_q;
    assign bus.m_addr    = addr_q;
    assign bus.m_din     = din_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: cycle-by-cycle vector table plus
// hand-written timeout and reset-during-issue sequences.
module tb_apb_req_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    apb_req_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed per-requester addresses and write data.
    assign bus.req_addr = {32'h30, 32'h0C, 32'h20, 32'h10};
    assign bus.req_din  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};

    function automatic logic [31:0] exp_addr(input logic [1:0] g);
        logic [31:0] t [4];
        t[0] = 32'h10; t[1] = 32'h20; t[2] = 32'h0C; t[3] = 32'h30;
        return t[g];
    endfunction

    typedef struct {
        logic       rst;
        logic [3:0] rv, rw, rl;
        logic       mr, dv;
        logic [7:0] dout;
        logic [3:0] e_rdy;
        logic       e_mv, e_wr;
        logic [3:0] e_rsp;
        logic       e_err;
        logic [1:0] e_gid;
        logic       e_busy;
        logic       cd;
        logic [7:0] e_data;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic [3:0] rv, rw, rl, input logic mr, dv,
                       input logic [7:0] dout, input logic [3:0] e_rdy, input logic e_mv, e_wr,
                       input logic [3:0] e_rsp, input logic e_err, input logic [1:0] e_gid,
                       input logic e_busy, input logic cd, input logic [7:0] e_data);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rw = rw; v.rl = rl; v.mr = mr; v.dv = dv; v.dout = dout;
        v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_wr = e_wr; v.e_rsp = e_rsp; v.e_err = e_err;
        v.e_gid = e_gid; v.e_busy = e_busy; v.cd = cd; v.e_data = e_data;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit seen;
        int mv_bad;

        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_write  = '0;
        bus.req_lock   = '0;
        bus.m_ready    = 1'b0;
        bus.m_dout_vld = 1'b0;
        bus.m_dout     = '0;
        repeat (3) @(posedge clk);

        //   rst rv   rw   rl   mr dv dout   rdy  mv wr rsp  err gid busy cd data
        add(0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1, 8'h00);
        // single write from requester 0
        add(1, 4'h1, 4'h1, 4'h0, 1, 0, 8'h00, 4'h1, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 0, 1, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0, 0, 4'h1, 0, 0, 0, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00);
        // reset, then all four requesters writing: order 0,1,2,3,0
        add(0, 4'h0, 4'h0, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1, 8'h00);
        add(1, 4'hF, 4'hF, 4'h0, 1, 0, 8'h00, 4'h1, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00);
        add(1, 4'hF, 4'hF, 4'h0, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 0, 1, 0, 8'h00);
        add(1, 4'hF, 4'hF, 4'h0, 1, 0, 8'h00, 4'h2, 0, 0, 4'h1, 0, 0, 0, 0, 8'h00);
        add(1, 4'hF, 4'hF, 4'h0, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 1, 1, 0, 8'h00);
        add(1, 4'hF, 4'hF, 4'h0, 1, 0, 8'h00, 4'h4, 0, 0, 4'h2, 0, 1, 0, 0, 8'h00);
        add(1, 4'hF, 4'hF, 4'h0, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 2, 1, 0, 8'h00);
        add(1, 4'hF, 4'hF, 4'h0, 1, 0, 8'h00, 4'h8, 0, 0, 4'h4, 0, 2, 0, 0, 8'h00);
        add(1, 4'hF, 4'hF, 4'h0, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 3, 1, 0, 8'h00);
        add(1, 4'hF, 4'hF, 4'h0, 1, 0, 8'h00, 4'h1, 0, 0, 4'h8, 0, 3, 0, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 0, 1, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0, 0, 4'h1, 0, 0, 0, 0, 8'h00);
        // requester 2 read, data 3 cycles after handshake, late data in IDLE ignored
        add(1, 4'h4, 4'h0, 4'h0, 1, 0, 8'h00, 4'h4, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 1, 0, 4'h0, 0, 2, 1, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 2, 1, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 2, 1, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 1, 8'h5A, 4'h0, 0, 0, 4'h0, 0, 2, 1, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0, 0, 4'h4, 0, 2, 0, 1, 8'h5A);
        add(1, 4'h0, 4'h0, 4'h0, 1, 1, 8'h77, 4'h0, 0, 0, 4'h0, 0, 2, 0, 1, 8'h5A);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 2, 0, 1, 8'h5A);
        // requester 1 locked writes (lock 1,1,0) while requester 0 waits
        add(1, 4'h2, 4'h2, 4'h2, 1, 0, 8'h00, 4'h2, 0, 0, 4'h0, 0, 2, 0, 0, 8'h00);
        add(1, 4'h3, 4'h2, 4'h2, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 1, 1, 0, 8'h00);
        add(1, 4'h3, 4'h2, 4'h2, 1, 0, 8'h00, 4'h2, 0, 0, 4'h2, 0, 1, 1, 0, 8'h00);
        add(1, 4'h3, 4'h2, 4'h0, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 1, 1, 0, 8'h00);
        add(1, 4'h3, 4'h2, 4'h0, 1, 0, 8'h00, 4'h2, 0, 0, 4'h2, 0, 1, 1, 0, 8'h00);
        add(1, 4'h1, 4'h3, 4'h0, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 1, 1, 0, 8'h00);
        add(1, 4'h1, 4'h3, 4'h0, 1, 0, 8'h00, 4'h1, 0, 0, 4'h2, 0, 1, 0, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 0, 1, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0, 0, 4'h1, 0, 0, 0, 1, 8'h5A);
        // lock held with no request stalls others, then releases to IDLE
        add(1, 4'h2, 4'h2, 4'h2, 1, 0, 8'h00, 4'h2, 0, 0, 4'h0, 0, 0, 0, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h2, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 1, 1, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h2, 1, 0, 8'h00, 4'h0, 0, 0, 4'h2, 0, 1, 1, 0, 8'h00);
        add(1, 4'h1, 4'h1, 4'h2, 1, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 1, 1, 0, 8'h00);
        add(1, 4'h1, 4'h1, 4'h0, 1, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 1, 1, 0, 8'h00);
        add(1, 4'h1, 4'h1, 4'h0, 1, 0, 8'h00, 4'h1, 0, 0, 4'h0, 0, 1, 0, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 0, 1, 0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 1, 0, 8'h00, 4'h0, 0, 0, 4'h1, 0, 0, 0, 0, 8'h00);

        foreach (vq[i]) begin
            @(negedge clk);
            rst_n          = vq[i].rst;
            bus.req_valid  = vq[i].rv;
            bus.req_write  = vq[i].rw;
            bus.req_lock   = vq[i].rl;
            bus.m_ready    = vq[i].mr;
            bus.m_dout_vld = vq[i].dv;
            bus.m_dout     = 32'(vq[i].dout);
            #1;
            chk($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(vq[i].e_rdy));
            chk($sformatf("row%0d m_valid", i), 32'(bus.m_valid), 32'(vq[i].e_mv));
            chk($sformatf("row%0d rsp_vld", i), 32'(bus.rsp_vld), 32'(vq[i].e_rsp));
            chk($sformatf("row%0d rsp_err", i), 32'(bus.rsp_err), 32'(vq[i].e_err));
            chk($sformatf("row%0d grant_id", i), 32'(bus.grant_id), 32'(vq[i].e_gid));
            chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(vq[i].e_busy));
            if (vq[i].e_mv) begin
                chk($sformatf("row%0d m_write", i), 32'(bus.m_write), 32'(vq[i].e_wr));
                chk($sformatf("row%0d m_addr", i), bus.m_addr, exp_addr(vq[i].e_gid));
                chk($sformatf("row%0d m_din", i), bus.m_din, 32'hC0 + 32'(vq[i].e_gid));
            end
            if (vq[i].cd)
                chk($sformatf("row%0d rsp_data", i), bus.rsp_data, 32'(vq[i].e_data));
        end

        // Read timeout from requester 3 (TIMEOUT=8), then a late data beat.
        @(negedge clk);
        bus.req_valid = 4'h8; bus.req_write = 4'h0; bus.req_lock = 4'h0;
        bus.m_ready = 1'b1; bus.m_dout_vld = 1'b0;
        #1 chk("to req_ready", 32'(bus.req_ready), 32'h8);
        @(negedge clk);
        bus.req_valid = 4'h0;
        #1;
        chk("to m_valid", 32'(bus.m_valid), 32'h1);
        chk("to m_addr", bus.m_addr, 32'h30);
        chk("to m_write", 32'(bus.m_write), 32'h0);
        @(posedge clk);
        n = 0; seen = 1'b0; mv_bad = 0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.rsp_vld != 0) seen = 1'b1;
            else if (bus.m_valid) mv_bad++;
        end
        chk("to edges", 32'(n), 32'd8);
        chk("to m_valid in wait", 32'(mv_bad), 32'd0);
        chk("to rsp_vld", 32'(bus.rsp_vld), 32'h8);
        chk("to rsp_err", 32'(bus.rsp_err), 32'h1);
        chk("to rsp_data", bus.rsp_data, 32'h0);
        chk("to busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        bus.m_dout_vld = 1'b1; bus.m_dout = 32'h99;
        @(negedge clk);
        bus.m_dout_vld = 1'b0;
        #1;
        chk("late rsp_vld", 32'(bus.rsp_vld), 32'h0);
        chk("late rsp_data", bus.rsp_data, 32'h0);
        chk("late busy", 32'(bus.busy), 32'h0);

        // Reset while an issue is stalled on m_ready.
        @(negedge clk);
        bus.req_valid = 4'h1; bus.req_write = 4'h1; bus.m_ready = 1'b0;
        #1 chk("rst req_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 4'h0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d m_valid", k), 32'(bus.m_valid), 32'h1);
            chk($sformatf("stall%0d m_addr", k), bus.m_addr, 32'h10);
            chk($sformatf("stall%0d m_din", k), bus.m_din, 32'hC0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("rst m_valid", 32'(bus.m_valid), 32'h0);
        chk("rst busy", 32'(bus.busy), 32'h0);
        chk("rst rsp_vld", 32'(bus.rsp_vld), 32'h0);
        bus.m_ready = 1'b1;
        @(negedge clk);
        #1 chk("rst hold rsp_vld", 32'(bus.rsp_vld), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post rst rsp_vld", 32'(bus.rsp_vld), 32'h0);
        chk("post rst busy", 32'(bus.busy), 32'h0);
        chk("post rst m_valid", 32'(bus.m_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
